// File: rtl/xbus_arbiter.sv
// Shared XBus arbiter: pairs one writer with one different reader and moves one word per transfer.
// Latency 1 cycle from the arbitration edge to the pulses; at most one transfer every 2 cycles.
module xbus_arbiter #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        wr_req,
  input  logic [NPORTS*WIDTH-1:0]  wr_dat,
  input  logic [NPORTS-1:0]        rd_req,
  output logic [NPORTS-1:0]        wr_done,
  output logic [NPORTS-1:0]        rd_valid,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     busy,
  output logic                     blocked
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic XFER = 1'b1;

  logic          state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] w_q, w_d;
  logic [PW-1:0] r_q, r_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic          blocked_q, blocked_d;

  logic          w_found, r_found, pair_vld;
  logic [PW-1:0] w_sel, r_sel;
  logic [WIDTH-1:0] wr_word [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign wr_word[g] = wr_dat[g*WIDTH +: WIDTH];
  end

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NPORTS) s = s - NPORTS;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(NPORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NPORTS-1:0] onehot(input logic [PW-1:0] p);
    logic [NPORTS-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // A writer is only taken if some other port is reading, so a port that
  // both writes and reads cannot stall a later writer that has a partner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!w_found && wr_req[rot(wr_ptr_q, k)] &&
          (|(rd_req & ~onehot(rot(wr_ptr_q, k))))) begin
        w_found = 1'b1;
        w_sel   = rot(wr_ptr_q, k);
      end
    end
    r_found = 1'b0;
    r_sel   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!r_found && rd_req[rot(rd_ptr_q, k)] && (rot(rd_ptr_q, k) != w_sel)) begin
        r_found = 1'b1;
        r_sel   = rot(rd_ptr_q, k);
      end
    end
    pair_vld = w_found && r_found;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    w_d       = w_q;
    r_d       = r_q;
    hold_d    = hold_q;
    blocked_d = 1'b0;
    if (state_q == IDLE) begin
      if (pair_vld) begin
        state_d = XFER;
        hold_d  = wr_word[w_sel];
        w_d     = w_sel;
        r_d     = r_sel;
      end else begin
        blocked_d = (|wr_req) || (|rd_req);
      end
    end else begin
      state_d  = IDLE;
      wr_ptr_d = inc(w_q);
      rd_ptr_d = inc(r_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      w_q       <= '0;
      r_q       <= '0;
      hold_q    <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      w_q       <= w_d;
      r_q       <= r_d;
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
    end
  end

  // Pulses decode straight from state so reset clears them without waiting for an edge.
  assign busy     = (state_q == XFER);
  assign wr_done  = busy ? onehot(w_q) : '0;
  assign rd_valid = busy ? onehot(r_q) : '0;
  assign rd_dat   = hold_q;
  assign blocked  = blocked_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed scenarios plus randomized requesters, all checked cycle by cycle against a transfer-level model.
module tb_xbus_arbiter;
  localparam int N = 4;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   wr_req = '0;
  logic [N-1:0]   rd_req = '0;
  logic [N*W-1:0] wr_dat;
  logic [W-1:0]   wdat [N];
  logic [N-1:0]   wr_done, rd_valid;
  logic [W-1:0]   rd_dat;
  logic           busy, blocked;

  int checks = 0;
  int errors = 0;

  // Model state: whether a transfer is showing, who is in it, and the round-robin starts.
  bit         m_xfer;
  int         m_wp, m_rp, m_w, m_r;
  logic [W-1:0] m_hold;
  bit         m_blk;

  logic [W-1:0] got [$];

  always #5 clk = ~clk;

  always_comb begin
    wr_dat = '0;
    for (int i = 0; i < N; i++) wr_dat[i*W +: W] = wdat[i];
  end

  xbus_arbiter #(.NPORTS(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_dat(wr_dat), .rd_req(rd_req),
    .wr_done(wr_done), .rd_valid(rd_valid), .rd_dat(rd_dat), .busy(busy), .blocked(blocked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xfer = 0; m_wp = 0; m_rp = 0; m_w = 0; m_r = 0; m_hold = '0; m_blk = 0;
  endtask

  // One clock edge of the transfer rules, from the inputs present before the edge.
  task automatic model_edge();
    bit found;
    int wi, ri;
    if (m_xfer) begin
      m_wp = (m_w + 1) % N;
      m_rp = (m_r + 1) % N;
      m_xfer = 0;
      m_blk = 0;
    end else begin
      found = 0;
      for (int a = 0; a < N && !found; a++) begin
        wi = (m_wp + a) % N;
        if (wr_req[wi]) begin
          for (int b = 0; b < N && !found; b++) begin
            ri = (m_rp + b) % N;
            if (ri != wi && rd_req[ri]) begin
              found = 1; m_w = wi; m_r = ri;
            end
          end
        end
      end
      if (found) begin
        m_xfer = 1;
        m_hold = wdat[m_w];
        m_blk = 0;
      end else begin
        m_blk = (wr_req != 0) || (rd_req != 0);
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ew, er;
    ew = '0; er = '0;
    if (m_xfer) begin ew[m_w] = 1'b1; er[m_r] = 1'b1; end
    check("busy", 32'(busy), 32'(m_xfer));
    check("wr_done", 32'(wr_done), 32'(ew));
    check("rd_valid", 32'(rd_valid), 32'(er));
    check("rd_dat", 32'(rd_dat), 32'(m_hold));
    check("blocked", 32'(blocked), 32'(m_blk));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wr_done"}, 32'(wr_done), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_dat"}, 32'(rd_dat), 32'd0);
    check({tag, "_blocked"}, 32'(blocked), 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    wr_req = '0; rd_req = '0;
    for (int i = 0; i < N; i++) wdat[i] = '0;
    model_reset();
    #3;
    check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) wdat[i] = '0;
    model_reset();

    // Single pair
    reset_dut();
    wdat[0] = 11'd123; wr_req = 4'b0001; rd_req = 4'b0100;
    tick();
    check("pair_rd_valid", 32'(rd_valid), 32'b0100);
    check("pair_rd_dat", 32'(rd_dat), 32'd123);
    check("pair_wr_done", 32'(wr_done), 32'b0001);
    check("pair_busy", 32'(busy), 32'd1);
    wr_req = '0; rd_req = '0;
    tick();
    check("pair_idle_rd_dat_held", 32'(rd_dat), 32'd123);

    // Writer round-robin with continuous requests
    reset_dut();
    wdat[0] = 11'd5; wdat[1] = 11'd6; wr_req = 4'b0011; rd_req = 4'b1000;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rd_valid != 0) got.push_back(rd_dat);
    end
    check("wrr_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("wrr_0", 32'(got[0]), 32'd5);
      check("wrr_1", 32'(got[1]), 32'd6);
      check("wrr_2", 32'(got[2]), 32'd5);
      check("wrr_3", 32'(got[3]), 32'd6);
    end

    // Self-exclusion, then a real reader arrives
    reset_dut();
    wdat[1] = 11'd7; wr_req = 4'b0010; rd_req = 4'b0010;
    tick();
    check("self_blocked", 32'(blocked), 32'd1);
    check("self_no_pulse", 32'(rd_valid | wr_done), 32'd0);
    tick();
    check("self_blocked2", 32'(blocked), 32'd1);
    rd_req = 4'b1010;
    tick();
    check("self_rd_valid", 32'(rd_valid), 32'b1000);
    check("self_rd_dat", 32'(rd_dat), 32'd7);
    check("self_wr_done", 32'(wr_done), 32'b0010);
    check("self_blocked_xfer", 32'(blocked), 32'd0);
    wr_req = '0; rd_req = 4'b0010;
    tick();

    // Reader fairness
    reset_dut();
    wdat[0] = 11'd300; wr_req = 4'b0001; rd_req = 4'b1110;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rd_valid != 0) got.push_back(W'(rd_valid));
    end
    check("rfair_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("rfair_0", 32'(got[0]), 32'b0010);
      check("rfair_1", 32'(got[1]), 32'b0100);
      check("rfair_2", 32'(got[2]), 32'b1000);
      check("rfair_3", 32'(got[3]), 32'b0010);
    end

    // Reset during the transfer cycle
    reset_dut();
    wdat[1] = 11'd44; wr_req = 4'b0010; rd_req = 4'b0100;
    tick();
    check("midrst_pre_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wdat[0] = 11'd11; wdat[1] = 11'd22; wr_req = 4'b0011; rd_req = 4'b1000;
    tick();
    check("midrst_restart_wr_done", 32'(wr_done), 32'b0001);
    check("midrst_restart_rd_dat", 32'(rd_dat), 32'd11);
    wr_req = '0; rd_req = '0;
    tick();

    // Extreme bit patterns pass unmodified
    reset_dut();
    wdat[0] = 11'h7FF; wr_req = 4'b0001; rd_req = 4'b0010;
    tick();
    check("wrap_7ff", 32'(rd_dat), 32'h7FF);
    wr_req = '0; rd_req = '0;
    tick();
    wdat[0] = 11'h400; wr_req = 4'b0001; rd_req = 4'b0010;
    tick();
    check("wrap_400", 32'(rd_dat), 32'h400);
    wr_req = '0; rd_req = '0;
    tick();

    // Randomized requesters; transfer participants may drop early inside the transfer cycle
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_xfer && i == m_w) begin
          if ($urandom_range(1, 0) == 1) wr_req[i] = 1'b0;
        end else if (!wr_req[i] && $urandom_range(2, 0) == 0) begin
          wr_req[i] = 1'b1;
          wdat[i] = W'($urandom_range(2047, 0));
        end
        if (m_xfer && i == m_r) begin
          if ($urandom_range(1, 0) == 1) rd_req[i] = 1'b0;
        end else if (!rd_req[i] && $urandom_range(2, 0) == 0) begin
          rd_req[i] = 1'b1;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 Parameter NPORTS, default 4, sets the number of controller ports sharing one XBus net (2..8).
REQ-002 Parameter WIDTH, default 11, sets the XBus data word width.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_req  input  NPORTS  per-port write request; held high until the matching wr_done pulse.
REQ-006 wr_dat  input  NPORTS*WIDTH  per-port write word; port i uses bits [i*WIDTH +: WIDTH], stable while wr_req[i] is high.
REQ-007 rd_req  input  NPORTS  per-port read request; held high until the matching rd_valid pulse.
REQ-008 wr_done  output  NPORTS  one-cycle pulse: the port's pending write was consumed.
REQ-009 rd_valid  output  NPORTS  one-cycle pulse: rd_dat holds the word for this port.
REQ-010 rd_dat  output  WIDTH  transferred word; broadcast to all ports, qualified by rd_valid.
REQ-011 busy  output  1  high while a transfer is in progress (state XFER).
REQ-012 blocked  output  1  high while requests are pending but no writer/reader pair can be formed.

Function
REQ-013 The block has a two-state FSM: IDLE and XFER.
REQ-014 In IDLE, a pair is eligible when some writer w and some reader r, with w != r, are both requesting.
REQ-015 The writer is chosen round-robin, starting the search at wr_ptr and ascending modulo NPORTS.
REQ-016 The reader is chosen round-robin, starting the search at rd_ptr and ascending modulo NPORTS, skipping port w.
REQ-017 On an eligible IDLE cycle, the block latches wr_dat[w] into a hold register, stores w and r, and moves to XFER.
REQ-018 In XFER for exactly one cycle, rd_dat = hold, rd_valid[r] = 1 and wr_done[w] = 1; the next state is IDLE.
REQ-019 Latency from the eligible IDLE edge to the rd_valid/wr_done pulse is 1 cycle.
REQ-020 Back-to-back transfers occur at most once every 2 cycles.
REQ-021 On the XFER edge, wr_ptr <= (w+1) mod NPORTS and rd_ptr <= (r+1) mod NPORTS; pointers wrap from NPORTS-1 to 0.
REQ-022 A transfer is committed once XFER is entered: dropping wr_req[w] or rd_req[r] during XFER does not cancel the pulses.
REQ-023 A port asserting both wr_req and rd_req never reads its own word, but may be chosen as reader of another port's write.
REQ-024 Each transfer delivers the word to exactly one reader; other readers keep waiting.
REQ-025 Data passes unmodified: no saturation or sign handling.
REQ-026 rd_dat holds its last value outside XFER.
REQ-027 blocked is registered: it is set on an IDLE edge where (|wr_req | |rd_req) is true and no pair is eligible, and cleared otherwise.
REQ-028 blocked is 0 whenever the FSM is in XFER.
REQ-029 Requests arriving during XFER are evaluated in the following IDLE cycle.
REQ-030 wr_done and rd_valid are never high outside XFER.

Reset
REQ-031 Assertion of rst_n low, at any time including mid-XFER, immediately forces: state = IDLE, wr_ptr = 0, rd_ptr = 0, hold = 0, rd_dat = 0, wr_done = 0, rd_valid = 0, busy = 0, blocked = 0.
REQ-032 A transfer interrupted by reset is lost; requesters re-arbitrate after reset deasserts.
REQ-033 The first eligible edge after reset release starts arbitration at port 0.

Verification
REQ-034 Single pair: after reset, port0 wr_req with 11'd123 and port2 rd_req -> next cycle rd_valid = 4'b0100, rd_dat = 123, wr_done = 4'b0001, busy = 1.
REQ-035 Writer round-robin: ports 0 and 1 write 5 and 6 continuously, port 3 reads continuously -> rd_dat sequence 5, 6, 5, 6 on every second cycle.
REQ-036 Self-exclusion: only port1 asserts both wr_req (7) and rd_req -> no pulses, and blocked = 1 from the second cycle; port3 then reads -> port3 receives 7 and wr_done[1] pulses.
REQ-037 Reader fairness: port0 writes continuously, ports 1, 2 and 3 read -> rd_valid cycles through ports 1, 2, 3, 1.
REQ-038 Reset mid-XFER: rst_n is pulled low in the XFER cycle -> all outputs are 0 asynchronously, and after release arbitration restarts at port 0.
REQ-039 Negative and wrap values: writing 11'h7FF and then 11'h400 -> both words are delivered bit-exact.
